// File: rtl/dac_wave_gen.sv
// Waveform sample source for the DAC7512 driver: phase accumulator, wave shaping,
// amplitude scaling, saturating offset and a valid/ready output register with overrun count.
`timescale 1ns/1ps
module dac_wave_gen #(
    parameter int unsigned TICK_DIV = 5000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        sync_clr,
    input  logic [1:0]  mode,
    input  logic [15:0] freq_word,
    input  logic [11:0] amp,
    input  logic [11:0] offset,
    input  logic [11:0] dc_code,
    output logic [11:0] data,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [7:0]  overrun_cnt
);
    localparam int unsigned CW = 16;
    localparam int unsigned PW = 16;
    localparam int unsigned DW = 12;
    localparam int unsigned OW = 8;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          tick_c;

    logic          s1_valid_q, s1_valid_d;
    logic          s1_bypass_q, s1_bypass_d;
    logic [DW-1:0] s1_raw_q, s1_raw_d;
    logic [DW-1:0] s1_amp_q, s1_amp_d;
    logic [DW-1:0] s1_off_q, s1_off_d;

    logic          s2_valid_q, s2_valid_d;
    logic          s2_bypass_q, s2_bypass_d;
    logic [DW-1:0] s2_scaled_q, s2_scaled_d;
    logic [DW-1:0] s2_off_q, s2_off_d;

    logic [DW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [OW-1:0] ovr_q, ovr_d;

    logic [DW-1:0]   raw_c;
    logic [2*DW-1:0] prod_c;
    logic [DW:0]     sum_c;
    logic [DW-1:0]   code_c;

    // sync_clr wins over a tick landing in the same cycle
    assign tick_c = en & ~sync_clr & (cnt_q == CW'(TICK_DIV - 1));

    // Wave shaping from the pre-update phase; DC code rides in the raw slot with a bypass flag
    always_comb begin
        raw_c = '0;
        case (mode)
            2'd0:    raw_c = dc_code;
            2'd1:    raw_c = phase_q[15:4];
            2'd2:    raw_c = phase_q[15] ? ~phase_q[14:3] : phase_q[14:3];
            default: raw_c = phase_q[15] ? '0 : {DW{1'b1}};
        endcase
    end

    assign prod_c = (2*DW)'(s1_raw_q) * (2*DW)'(s1_amp_q);
    assign sum_c  = (DW+1)'(s2_scaled_q) + (DW+1)'(s2_off_q);
    assign code_c = s2_bypass_q ? s2_scaled_q
                  : (sum_c[DW] ? {DW{1'b1}} : sum_c[DW-1:0]);

    always_comb begin
        cnt_d       = cnt_q;
        phase_d     = phase_q;
        s1_valid_d  = tick_c;
        s1_bypass_d = s1_bypass_q;
        s1_raw_d    = s1_raw_q;
        s1_amp_d    = s1_amp_q;
        s1_off_d    = s1_off_q;
        s2_valid_d  = s1_valid_q;
        s2_bypass_d = s2_bypass_q;
        s2_scaled_d = s2_scaled_q;
        s2_off_d    = s2_off_q;
        data_d      = data_q;
        valid_d     = valid_q;
        ovr_d       = ovr_q;

        if (sync_clr) begin
            cnt_d   = '0;
            phase_d = '0;
        end else if (en) begin
            cnt_d = tick_c ? '0 : cnt_q + CW'(1);
            if (tick_c) begin
                phase_d = phase_q + freq_word;
            end
        end

        if (tick_c) begin
            s1_bypass_d = (mode == 2'd0);
            s1_raw_d    = raw_c;
            s1_amp_d    = amp;
            s1_off_d    = offset;
        end

        if (s1_valid_q) begin
            s2_bypass_d = s1_bypass_q;
            s2_scaled_d = s1_bypass_q ? s1_raw_q : prod_c[2*DW-1:DW];
            s2_off_d    = s1_off_q;
        end

        // Output register: load when empty or draining, otherwise drop and count
        if (s2_valid_q) begin
            if (!valid_q || data_ready) begin
                data_d  = code_c;
                valid_d = 1'b1;
            end else if (ovr_q != {OW{1'b1}}) begin
                ovr_d = ovr_q + OW'(1);
            end
        end else if (valid_q && data_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            phase_q     <= '0;
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_raw_q    <= '0;
            s1_amp_q    <= '0;
            s1_off_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_bypass_q <= 1'b0;
            s2_scaled_q <= '0;
            s2_off_q    <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            ovr_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            phase_q     <= phase_d;
            s1_valid_q  <= s1_valid_d;
            s1_bypass_q <= s1_bypass_d;
            s1_raw_q    <= s1_raw_d;
            s1_amp_q    <= s1_amp_d;
            s1_off_q    <= s1_off_d;
            s2_valid_q  <= s2_valid_d;
            s2_bypass_q <= s2_bypass_d;
            s2_scaled_q <= s2_scaled_d;
            s2_off_q    <= s2_off_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = valid_q;
    assign overrun_cnt = ovr_q;

endmodule

// File: tb/tb_dac_wave_gen.sv
// Scoreboard bench for dac_wave_gen at TICK_DIV=4: stimulus pushes expected codes,
// a negedge monitor pops and compares on every accepted transfer.
`timescale 1ns/1ps
module tb_dac_wave_gen;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        sync_clr;
    logic [1:0]  mode;
    logic [15:0] freq_word;
    logic [11:0] amp;
    logic [11:0] offset;
    logic [11:0] dc_code;
    logic [11:0] data;
    logic        data_valid;
    logic        data_ready;
    logic [7:0]  overrun_cnt;

    int checks = 0;
    int passes = 0;
    logic [11:0] exp_q[$];
    logic [11:0] mon_e;

    logic [11:0] saw_exp [17] = '{0, 255, 511, 767, 1023, 1279, 1535, 1791, 2047,
                                  2303, 2559, 2815, 3071, 3327, 3583, 3839, 0};
    logic [11:0] tri_exp [9]  = '{2048, 3071, 4095, 4095, 4095, 4095, 4094, 3070, 2048};

    dac_wave_gen #(.TICK_DIV(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync_clr    (sync_clr),
        .mode        (mode),
        .freq_word   (freq_word),
        .amp         (amp),
        .offset      (offset),
        .dc_code     (dc_code),
        .data        (data),
        .data_valid  (data_valid),
        .data_ready  (data_ready),
        .overrun_cnt (overrun_cnt)
    );

    always #10 clk = ~clk;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act == expv) passes++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every cycle where a transfer will occur is one produced sample
    always @(negedge clk) begin
        if (rst_n && data_valid && data_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_sample", int'(data), -1);
            end else begin
                mon_e = exp_q.pop_front();
                chk("sample", int'(data), int'(mon_e));
            end
        end
    end

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) step();
        chk({name, "_drain"}, exp_q.size(), 0);
        chk({name, "_idle"}, int'(data_valid), 0);
    endtask

    task automatic setup(input logic [1:0] m, input logic [15:0] fw, input logic [11:0] a,
                         input logic [11:0] off, input logic [11:0] dc);
        mode = m; freq_word = fw; amp = a; offset = off; dc_code = dc;
        en = 1'b0;
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
    endtask

    task automatic run_ticks(input int n);
        en = 1'b1;
        step(4 * n);
        en = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int highs;
        rst_n = 1'b0; en = 1'b0; sync_clr = 1'b0; mode = 2'd0; freq_word = '0;
        amp = '0; offset = '0; dc_code = '0; data_ready = 1'b0;

        // Reset held with inputs toggling
        for (int i = 0; i < 4; i++) begin
            en = 1'b1; sync_clr = 1'($urandom); mode = 2'($urandom);
            freq_word = 16'($urandom); amp = 12'($urandom); offset = 12'($urandom);
            dc_code = 12'($urandom); data_ready = 1'($urandom);
            step();
            chk("rst_data", int'(data), 0);
            chk("rst_valid", int'(data_valid), 0);
            chk("rst_ovr", int'(overrun_cnt), 0);
        end
        en = 1'b0; sync_clr = 1'b0; data_ready = 1'b1;
        rst_n = 1'b1;
        step(8);
        chk("rst_release_valid", int'(data_valid), 0);

        // DC mode, latency and cadence
        setup(2'd0, 16'h0, 12'd0, 12'd0, 12'd1638);
        repeat (3) exp_q.push_back(12'd1638);
        en = 1'b1;
        step(5);
        chk("dc_valid_c5", int'(data_valid), 0);
        step();
        chk("dc_valid_c6", int'(data_valid), 1);
        chk("dc_data_c6", int'(data), 1638);
        step(6);
        en = 1'b0;
        drain("dc");
        chk("dc_ovr", int'(overrun_cnt), 0);

        // Sawtooth with wrap on the 17th sample
        setup(2'd1, 16'h1000, 12'd4095, 12'd0, 12'd0);
        foreach (saw_exp[i]) exp_q.push_back(saw_exp[i]);
        run_ticks(17);
        drain("saw");

        // Triangle with offset saturation
        setup(2'd2, 16'h2000, 12'd4095, 12'd2048, 12'd0);
        foreach (tri_exp[i]) exp_q.push_back(tri_exp[i]);
        run_ticks(9);
        drain("tri");
        chk("tri_ovr", int'(overrun_cnt), 0);

        // sync_clr mid-run restarts phase and divider
        setup(2'd1, 16'h1000, 12'd4095, 12'd0, 12'd0);
        exp_q.push_back(12'd0); exp_q.push_back(12'd255); exp_q.push_back(12'd0);
        en = 1'b1;
        step(10);
        sync_clr = 1'b1;
        step();
        sync_clr = 1'b0;
        step(4);
        en = 1'b0;
        drain("sync_clr");

        // Backpressure from reset: square, 3 ticks with data_ready low
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        data_ready = 1'b0;
        mode = 2'd3; freq_word = 16'h1000; amp = 12'd4095; offset = 12'd0;
        run_ticks(3);
        step(5);
        chk("bp_valid", int'(data_valid), 1);
        chk("bp_data", int'(data), 4094);
        chk("bp_ovr", int'(overrun_cnt), 2);
        step(3);
        chk("bp_data_stable", int'(data), 4094);
        exp_q.push_back(12'd4094);
        data_ready = 1'b1;
        step();
        data_ready = 1'b0;
        chk("bp_after_xfer_valid", int'(data_valid), 0);
        chk("bp_queue", exp_q.size(), 0);

        // Long stall saturates the overrun counter
        run_ticks(300);
        step(5);
        chk("stall_ovr_sat", int'(overrun_cnt), 255);
        chk("stall_data", int'(data), 4094);
        exp_q.push_back(12'd4094);
        data_ready = 1'b1;
        step();
        chk("stall_after_xfer_valid", int'(data_valid), 0);
        chk("stall_queue", exp_q.size(), 0);

        // Asynchronous reset while a sample sits in S2
        setup(2'd1, 16'h1000, 12'd4095, 12'd1000, 12'd0);
        en = 1'b1;
        step(5);
        rst_n = 1'b0;
        en = 1'b0;
        #1;
        chk("midrst_ovr_async", int'(overrun_cnt), 0);
        step(2);
        rst_n = 1'b1;
        highs = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (data_valid) highs++;
        end
        chk("midrst_no_valid", highs, 0);
        chk("midrst_data", int'(data), 0);
        chk("midrst_ovr", int'(overrun_cnt), 0);
        chk("midrst_queue", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
